// File: rtl/reloj_time_setter_if.sv
// Button, current-time and adjust-bus bundle between the time setter and its neighbours.
// The master side is the time setter: it reads the buttons and current time, and drives the adjust outputs.
interface reloj_time_setter_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hora;
    logic [3:0] cur_dmin;
    logic [3:0] cur_umin;
    logic [3:0] ajust_hora;
    logic [3:0] ajust_dmin;
    logic [3:0] ajust_umin;
    logic       ajust_load;
    logic       editing;
    logic [1:0] field;
    logic       blink;

    modport master (
        input  btn_mode, btn_inc, cur_hora, cur_dmin, cur_umin,
        output ajust_hora, ajust_dmin, ajust_umin, ajust_load, editing, field, blink
    );

    modport slave (
        output btn_mode, btn_inc, cur_hora, cur_dmin, cur_umin,
        input  ajust_hora, ajust_dmin, ajust_umin, ajust_load, editing, field, blink
    );
endinterface

// File: rtl/reloj_time_setter.sv
// Time-setting front end for the 12-hour clock: debounces mode/inc buttons, edits hour,
// tens and units of minutes in turn, and commits the result with a one-cycle load strobe.
module reloj_time_setter #(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [23:0] BLINK_DIV  = 24'd6000000,
    parameter logic [31:0] TIMEOUT    = 32'd300000000
) (
    input logic                 clock,
    input logic                 resetn,
    reloj_time_setter_if.master bus
);
    typedef enum logic [2:0] {IDLE, SET_H, SET_D, SET_U, LOAD} state_t;

    logic [1:0] btn_raw;
    logic [1:0] press;
    assign btn_raw = {bus.btn_inc, bus.btn_mode};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_btn
            logic        sync1_reg;
            logic        sync2_reg;
            logic        level_reg;
            logic [15:0] cnt_reg;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    level_reg <= 1'b0;
                    cnt_reg   <= 16'd0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg != level_reg) begin
                        if (cnt_reg == DEB_CYCLES - 16'd1) begin
                            level_reg <= sync2_reg;
                            cnt_reg   <= 16'd0;
                        end else begin
                            cnt_reg <= cnt_reg + 16'd1;
                        end
                    end else begin
                        cnt_reg <= 16'd0;
                    end
                end
            end

            // Pulse during the cycle whose edge flips the accepted level 0->1, so the FSM acts on that same edge.
            assign press[gi] = sync2_reg & ~level_reg & (cnt_reg == DEB_CYCLES - 16'd1);
        end
    endgenerate

    logic mode_press;
    logic inc_press;
    logic timeout_hit;
    assign mode_press = press[0];
    assign inc_press  = press[1];

    state_t      state_reg;
    logic [3:0]  hora_reg, dmin_reg, umin_reg;
    logic [3:0]  bak_hora_reg, bak_dmin_reg, bak_umin_reg;
    logic        load_reg;
    logic        editing_reg;
    logic [1:0]  field_reg;
    logic        blink_reg;
    logic [23:0] blink_cnt_reg;
    logic [31:0] to_cnt_reg;

    assign timeout_hit = (to_cnt_reg == TIMEOUT - 32'd1) & ~mode_press & ~inc_press;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            hora_reg      <= 4'd1;
            dmin_reg      <= 4'd0;
            umin_reg      <= 4'd0;
            bak_hora_reg  <= 4'd1;
            bak_dmin_reg  <= 4'd0;
            bak_umin_reg  <= 4'd0;
            load_reg      <= 1'b0;
            editing_reg   <= 1'b0;
            field_reg     <= 2'd0;
            blink_reg     <= 1'b0;
            blink_cnt_reg <= 24'd0;
            to_cnt_reg    <= 32'd0;
        end else begin
            load_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    blink_reg     <= 1'b0;
                    blink_cnt_reg <= 24'd0;
                    to_cnt_reg    <= 32'd0;
                    if (mode_press) begin
                        // Remember the committed values so an abandoned edit can be undone.
                        bak_hora_reg <= hora_reg;
                        bak_dmin_reg <= dmin_reg;
                        bak_umin_reg <= umin_reg;
                        hora_reg     <= (bus.cur_hora == 4'd0 || bus.cur_hora > 4'd12) ? 4'd1 : bus.cur_hora;
                        dmin_reg     <= (bus.cur_dmin > 4'd5) ? 4'd0 : bus.cur_dmin;
                        umin_reg     <= (bus.cur_umin > 4'd9) ? 4'd0 : bus.cur_umin;
                        state_reg    <= SET_H;
                        field_reg    <= 2'd1;
                        editing_reg  <= 1'b1;
                        blink_reg    <= 1'b1;
                    end
                end
                SET_H, SET_D, SET_U: begin
                    if (mode_press) begin
                        to_cnt_reg    <= 32'd0;
                        blink_cnt_reg <= 24'd0;
                        blink_reg     <= 1'b1;
                        if (state_reg == SET_H) begin
                            state_reg <= SET_D;
                            field_reg <= 2'd2;
                        end else if (state_reg == SET_D) begin
                            state_reg <= SET_U;
                            field_reg <= 2'd3;
                        end else begin
                            state_reg   <= LOAD;
                            field_reg   <= 2'd0;
                            editing_reg <= 1'b0;
                            blink_reg   <= 1'b0;
                            load_reg    <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_reg   <= IDLE;
                        hora_reg    <= bak_hora_reg;
                        dmin_reg    <= bak_dmin_reg;
                        umin_reg    <= bak_umin_reg;
                        field_reg   <= 2'd0;
                        editing_reg <= 1'b0;
                        blink_reg   <= 1'b0;
                        to_cnt_reg  <= 32'd0;
                    end else begin
                        to_cnt_reg <= inc_press ? 32'd0 : to_cnt_reg + 32'd1;
                        if (inc_press) begin
                            if (state_reg == SET_H)
                                hora_reg <= (hora_reg == 4'd12) ? 4'd1 : hora_reg + 4'd1;
                            else if (state_reg == SET_D)
                                dmin_reg <= (dmin_reg == 4'd5) ? 4'd0 : dmin_reg + 4'd1;
                            else
                                umin_reg <= (umin_reg == 4'd9) ? 4'd0 : umin_reg + 4'd1;
                        end
                        if (blink_cnt_reg == BLINK_DIV - 24'd1) begin
                            blink_cnt_reg <= 24'd0;
                            blink_reg     <= ~blink_reg;
                        end else begin
                            blink_cnt_reg <= blink_cnt_reg + 24'd1;
                        end
                    end
                end
                LOAD: begin
                    state_reg <= IDLE;
                    blink_reg <= 1'b0;
                end
                default: begin
                    state_reg   <= IDLE;
                    field_reg   <= 2'd0;
                    editing_reg <= 1'b0;
                    blink_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ajust_hora = hora_reg;
    assign bus.ajust_dmin = dmin_reg;
    assign bus.ajust_umin = umin_reg;
    assign bus.ajust_load = load_reg;
    assign bus.editing    = editing_reg;
    assign bus.field      = field_reg;
    assign bus.blink      = blink_reg;
endmodule

// File: tb/tb_reloj_time_setter.sv
// Scoreboard bench for reloj_time_setter: expected commits are queued when issued and
// popped by a monitor on every load strobe; state/field/blink are checked inline.
module tb_reloj_time_setter;
    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    reloj_time_setter_if bus();

    reloj_time_setter #(
        .DEB_CYCLES(16'd4),
        .BLINK_DIV (24'd8),
        .TIMEOUT   (32'd64)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [11:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every load strobe must match the oldest queued commit.
    always @(negedge clock) begin
        if (resetn === 1'b1 && bus.ajust_load === 1'b1) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_load: got load with %h expected no load",
                         {bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin});
            end else begin
                logic [11:0] e;
                e = sb.pop_front();
                check("load_value", int'({bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin}), int'(e));
                $display("load %h expected %h", {bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin}, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_press(input logic m, input logic i);
        @(posedge clock); #1;
        bus.btn_mode = m;
        bus.btn_inc  = i;
        repeat (10) @(posedge clock);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        $display("press mode=%0b inc=%0b -> field=%0d ajust=%h", m, i, bus.field,
                 {bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin});
    endtask

    task automatic set_cur(input logic [3:0] h, input logic [3:0] d, input logic [3:0] u);
        bus.cur_hora = h;
        bus.cur_dmin = d;
        bus.cur_umin = u;
    endtask

    task automatic check_outs(input string tag, input int f, input int h, input int d, input int u);
        check({tag, "_field"}, int'(bus.field), f);
        check({tag, "_hora"},  int'(bus.ajust_hora), h);
        check({tag, "_dmin"},  int'(bus.ajust_dmin), d);
        check({tag, "_umin"},  int'(bus.ajust_umin), u);
    endtask

    // Full edit from 11:59: {mode, inc, field, hora, dmin, umin} after each press.
    typedef struct {logic m; logic i; int f; int h; int d; int u;} step_t;
    step_t steps[9];

    initial begin
        steps[0] = '{1'b1, 1'b0, 1, 11, 5, 9};
        steps[1] = '{1'b0, 1'b1, 1, 12, 5, 9};
        steps[2] = '{1'b0, 1'b1, 1,  1, 5, 9};
        steps[3] = '{1'b1, 1'b0, 2,  1, 5, 9};
        steps[4] = '{1'b0, 1'b1, 2,  1, 0, 9};
        steps[5] = '{1'b1, 1'b0, 3,  1, 0, 9};
        steps[6] = '{1'b0, 1'b1, 3,  1, 0, 0};
        steps[7] = '{1'b0, 1'b1, 3,  1, 0, 1};
        steps[8] = '{1'b1, 1'b0, 0,  1, 0, 1};

        resetn       = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        set_cur(4'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clock);
        #1;
        check_outs("reset", 0, 1, 0, 0);
        check("reset_load",    int'(bus.ajust_load), 0);
        check("reset_editing", int'(bus.editing), 0);
        check("reset_blink",   int'(bus.blink), 0);
        resetn = 1'b1;

        // 3-cycle glitch must not be accepted.
        @(posedge clock); #1;
        bus.btn_mode = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        bus.btn_mode = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("glitch_field",   int'(bus.field), 0);
        check("glitch_editing", int'(bus.editing), 0);

        // Clean held press: SET_H exactly 6 edges after the raw edge, and only once.
        set_cur(4'd5, 4'd2, 4'd3);
        @(posedge clock); #1;
        for (int t = 0; t <= 48; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            bus.btn_mode = (t < 40);
            if (t == 5)  check("deb_before_field", int'(bus.field), 0);
            if (t == 6)  check("deb_latency_field", int'(bus.field), 1);
            if (t == 6)  check("deb_entry_hora", int'(bus.ajust_hora), 5);
            if (t == 39) check("deb_hold_field", int'(bus.field), 1);
            if (t == 48) check("deb_release_field", int'(bus.field), 1);
        end
        $display("debounce press -> field=%0d", bus.field);

        // Simultaneous mode+inc in SET_H: mode wins, hour untouched.
        do_press(1'b1, 1'b1);
        check_outs("simul", 2, 5, 2, 3);
        do_press(1'b1, 1'b0);
        check("simul_to_u", int'(bus.field), 3);
        sb.push_back(12'h523);
        do_press(1'b1, 1'b0);
        check("simul_done_editing", int'(bus.editing), 0);

        // Full edit from 11:59.
        set_cur(4'd11, 4'd5, 4'd9);
        for (int k = 0; k < 9; k++) begin
            if (k == 8) sb.push_back(12'h101);
            do_press(steps[k].m, steps[k].i);
            check_outs($sformatf("edit%0d", k), steps[k].f, steps[k].h, steps[k].d, steps[k].u);
        end

        // Clamping of out-of-range current time.
        set_cur(4'd0, 4'd7, 4'd12);
        do_press(1'b1, 1'b0);
        check_outs("clamp", 1, 1, 0, 0);
        do_press(1'b1, 1'b0);
        do_press(1'b1, 1'b0);
        sb.push_back(12'h100);
        do_press(1'b1, 1'b0);

        // Commit 3:00 so the timeout revert target is known.
        set_cur(4'd3, 4'd0, 4'd0);
        do_press(1'b1, 1'b0);
        do_press(1'b1, 1'b0);
        do_press(1'b1, 1'b0);
        sb.push_back(12'h300);
        do_press(1'b1, 1'b0);

        // Timeout: enter at edge 6, inc at edge 26, abort at edge 90; blink half-period 8.
        @(posedge clock); #1;
        for (int t = 0; t <= 100; t++) begin
            if (t > 0) begin
                @(posedge clock); #1;
            end
            bus.btn_mode = (t < 10);
            bus.btn_inc  = (t >= 20 && t < 30);
            if (t == 6)  check_outs("to_entry", 1, 3, 0, 0);
            if (t == 6)  check("to_blink_entry", int'(bus.blink), 1);
            if (t == 13) check("to_blink13", int'(bus.blink), 1);
            if (t == 14) check("to_blink14", int'(bus.blink), 0);
            if (t == 21) check("to_blink21", int'(bus.blink), 0);
            if (t == 22) check("to_blink22", int'(bus.blink), 1);
            if (t == 25) check("to_hora_pre_inc", int'(bus.ajust_hora), 3);
            if (t == 26) check("to_hora_inc", int'(bus.ajust_hora), 4);
            if (t == 29) check("to_blink29", int'(bus.blink), 1);
            if (t == 30) check("to_blink30", int'(bus.blink), 0);
            if (t == 89) check_outs("to_pre_expire", 1, 4, 0, 0);
            if (t == 89) check("to_blink89", int'(bus.blink), 1);
            if (t == 90) check_outs("to_expired", 0, 3, 0, 0);
            if (t == 90) check("to_blink_exit", int'(bus.blink), 0);
            if (t == 90) check("to_editing_exit", int'(bus.editing), 0);
            if (t == 100) check("to_idle_blink", int'(bus.blink), 0);
        end
        $display("timeout -> field=%0d ajust=%h", bus.field,
                 {bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin});

        // Reset in SET_D: immediate async clear, no load.
        set_cur(4'd7, 4'd4, 4'd1);
        do_press(1'b1, 1'b0);
        check("rst_edit_hora", int'(bus.ajust_hora), 7);
        do_press(1'b1, 1'b0);
        check("rst_edit_field", int'(bus.field), 2);
        @(posedge clock); #3;
        resetn = 1'b0;
        #1;
        check_outs("async_rst", 0, 1, 0, 0);
        check("async_rst_load",    int'(bus.ajust_load), 0);
        check("async_rst_editing", int'(bus.editing), 0);
        check("async_rst_blink",   int'(bus.blink), 0);
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        check("post_rst_field", int'(bus.field), 0);
        $display("reset mid-edit -> field=%0d ajust=%h", bus.field,
                 {bus.ajust_hora, bus.ajust_dmin, bus.ajust_umin});

        repeat (5) @(posedge clock);
        #1;
        check("pending_loads", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reloj_time_setter.md
Name: reloj_time_setter

Overview:
- Button-driven time-setting front end for the 12-hour clock.
- Produces the hour, tens-of-minutes and units-of-minutes adjust values, plus the load strobe that the time-keeping counter consumes when the user sets the time.
- Debounces two push-buttons and walks an edit FSM through hour, then tens of minutes, then units of minutes.
- Commits the edited values with a single-cycle load pulse, and drives a blink indication for the field being edited.

Parameters:
- DEB_CYCLES, 16'd50000, consecutive identical synchronized samples required before a button level is accepted.
- BLINK_DIV, 24'd6000000, clock cycles per half-period of blink while editing.
- TIMEOUT, 32'd300000000, idle cycles in any SET state before the edit is aborted without load.

Ports:
- clock, input, 1, single system clock; all state changes on its rising edge.
- resetn, input, 1, asynchronous active-low reset.
- btn_mode, input, 1, raw mode button, asynchronous, active-high.
- btn_inc, input, 1, raw increment button, asynchronous, active-high.
- cur_hora, input, 4, current running hour (1..12), sampled on edit entry.
- cur_dmin, input, 4, current tens of minutes (0..5), sampled on edit entry.
- cur_umin, input, 4, current units of minutes (0..9), sampled on edit entry.
- ajust_hora, output, 4, edited hour value.
- ajust_dmin, output, 4, edited tens of minutes.
- ajust_umin, output, 4, edited units of minutes.
- ajust_load, output, 1, one-cycle commit strobe; the adjust values are valid whenever it is high.
- editing, output, 1, high in every SET state.
- field, output, 2, field being edited: 0 none, 1 hour, 2 dmin, 3 umin.
- blink, output, 1, blink phase for the edited field; 0 when not editing.

Behaviour:
- Reset (resetn low, async):
  - FSM goes to IDLE.
  - ajust_hora=1, ajust_dmin=0, ajust_umin=0.
  - ajust_load=0, editing=0, field=0, blink=0.
  - Synchronizers, debounce counters, blink counter and timeout counter cleared to 0.
  - Reset asserted mid-edit discards the edit; no load is issued.
- Button path, per button:
  - 2-FF synchronizer, then debounce counter.
  - The counter increments while the synchronized sample differs from the accepted level, and clears when they are equal.
  - When the count reaches DEB_CYCLES-1, the accepted level flips and the counter clears.
  - A 0->1 transition of the accepted level produces a one-cycle press pulse.
  - Press latency from a clean raw edge = 2 + DEB_CYCLES cycles.
  - Holding a button produces exactly one pulse (no auto-repeat).
- FSM states: IDLE, SET_H, SET_D, SET_U, LOAD.
- IDLE:
  - mode press -> SET_H.
  - Edit registers are loaded from cur_* with clamping:
    - hora: 0 or >12 -> 1.
    - dmin: >5 -> 0.
    - umin: >9 -> 0.
  - inc press is ignored.
- SET_H:
  - inc press: hora 12 -> 1, else +1.
  - mode press -> SET_D.
- SET_D:
  - inc press: dmin 5 -> 0, else +1.
  - mode press -> SET_U.
- SET_U:
  - inc press: umin 9 -> 0, else +1.
  - mode press -> LOAD.
- LOAD:
  - ajust_load=1 for exactly this one cycle.
  - Unconditional return to IDLE on the next cycle.
  - Presses arriving in LOAD are dropped.
- Simultaneous mode and inc press in the same cycle: mode wins; the increment is not applied.
- Increments only touch the field of the current state; the other edit registers hold.
- ajust_* outputs are driven directly from the edit registers and hold their last value in IDLE.
- Timeout:
  - The counter clears on any press and on entering SET_H.
  - It increments in SET states.
  - Reaching TIMEOUT-1 -> IDLE with no load.
  - Edit registers revert to their pre-edit contents, so ajust_* are unchanged since the last commit.
- Blink:
  - The counter clears and blink is forced to 1 on entering SET_H and on every field change.
  - blink toggles every BLINK_DIV cycles in SET states.
  - blink=0 in IDLE and LOAD.
- field = 1/2/3 in SET_H/SET_D/SET_U; 0 otherwise. editing = field != 0.

Test Plan (DEB_CYCLES=4, BLINK_DIV=8, TIMEOUT=64):
- Reset: assert resetn=0 mid-sim -> ajust_hora=1, ajust_dmin=0, ajust_umin=0, all other outputs 0, immediately and asynchronously. Pulse mode then reset during SET_D -> IDLE, ajust_load never asserted.
- Debounce: 3-cycle glitch on btn_mode -> no state change. Clean press held 40 cycles -> SET_H entered once, 6 cycles after the raw edge.
- Full edit:
  - Start from cur = 11:59 (hora=11, dmin=5, umin=9).
  - Actions: mode, inc, inc, mode, inc, mode, inc, inc, mode.
  - Expected: hora 11->12->1, dmin 5->0, umin 9->0->1.
  - Single ajust_load pulse with ajust = 1:01.
- Clamping: cur_hora=0, cur_dmin=7, cur_umin=12, then mode -> edit registers = 1, 0, 0.
- Simultaneous press in SET_H: mode and inc debounced in the same cycle -> SET_D, hora unchanged.
- Timeout: enter SET_H, inc once (hora 3->4), then no presses for 64 cycles -> IDLE, no load, ajust_hora back to 3. Blink toggles every 8 cycles while in SET_H and is 0 after exit.
